// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped cache controller between the core data port and one cache_set.
// It sequences lookup, hit completion, dirty writeback and single-word refill, and counts hit, miss and writeback events.
module cache_ctrl #(
   parameter int unsigned CACHE_LINE_SIZE = 4,
   parameter int unsigned CACHE_SET_DEPTH = 32,
   localparam int unsigned DATA_WIDTH = 32,
   localparam int unsigned OFFSET_W   = $clog2(CACHE_LINE_SIZE),
   localparam int unsigned INDEX_W    = $clog2(CACHE_SET_DEPTH),
   localparam int unsigned TAG_W      = DATA_WIDTH - OFFSET_W - INDEX_W
) (
   input  logic                  clk,
   input  logic                  rst,
   // core side
   input  logic                  core_read,
   input  logic                  core_write,
   input  logic [DATA_WIDTH-1:0] core_address,
   input  logic [DATA_WIDTH-1:0] core_writedata,
   input  logic [3:0]            core_byteenable,
   output logic [DATA_WIDTH-1:0] core_readdata,
   output logic                  core_waitrequest,
   // cache_set access port
   output logic                  set_read,
   output logic                  set_write,
   output logic [DATA_WIDTH-1:0] set_address,
   output logic [DATA_WIDTH-1:0] set_writedata,
   output logic [3:0]            set_byteenable,
   input  logic [DATA_WIDTH-1:0] set_readdata,
   input  logic                  set_hit,
   input  logic                  set_valid,
   input  logic                  set_dirty,
   input  logic [DATA_WIDTH-1:0] set_dirty_data,
   input  logic [TAG_W-1:0]      set_tag,
   // cache_set fill port
   output logic                  set_fill,
   output logic [DATA_WIDTH-1:0] set_fill_address,
   output logic [DATA_WIDTH-1:0] set_fill_data,
   // memory side
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [DATA_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_writedata,
   output logic [3:0]            mem_byteenable,
   input  logic [DATA_WIDTH-1:0] mem_readdata,
   input  logic                  mem_readdatavalid,
   input  logic                  mem_waitrequest,
   // event counters
   output logic [31:0]           cnt_hit,
   output logic [31:0]           cnt_miss,
   output logic [31:0]           cnt_wb
);

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WRITEBACK,
      REFILL,
      REFILL_WAIT
   } state_t;

   state_t state, state_next;

   logic                  req;
   logic                  done;
   logic                  miss;
   logic                  wb_done;
   logic [INDEX_W-1:0]    index;
   logic [DATA_WIDTH-1:0] victim_addr;
   logic [DATA_WIDTH-1:0] victim_data;

   assign req              = core_read | core_write;
   assign index            = core_address[OFFSET_W +: INDEX_W];
   assign core_waitrequest = req & ~done;
   assign set_address      = core_address;
   assign set_writedata    = core_writedata;
   assign set_byteenable   = core_byteenable;
   assign mem_byteenable   = 4'hF;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state and per-state output decode
   always_comb begin
      state_next       = state;
      done             = 1'b0;
      miss             = 1'b0;
      wb_done          = 1'b0;
      set_read         = 1'b0;
      set_write        = 1'b0;
      set_fill         = 1'b0;
      set_fill_address = '0;
      set_fill_data    = '0;
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      mem_address      = '0;
      mem_writedata    = '0;
      core_readdata    = '0;
      case (state)
         IDLE: begin
            if (req) state_next = LOOKUP;
         end
         LOOKUP: begin
            // a simultaneous read and write is treated as a write
            set_write = core_write;
            set_read  = core_read & ~core_write;
            if (!req) begin
               state_next = IDLE;
            end else if (set_hit) begin
               done       = 1'b1;
               state_next = IDLE;
               if (core_read && !core_write) core_readdata = set_readdata;
            end else begin
               miss       = 1'b1;
               state_next = (set_valid && set_dirty) ? WRITEBACK : REFILL;
            end
         end
         WRITEBACK: begin
            mem_write     = 1'b1;
            mem_address   = victim_addr;
            mem_writedata = victim_data;
            if (!mem_waitrequest) begin
               wb_done    = 1'b1;
               state_next = REFILL;
            end
         end
         REFILL: begin
            mem_read    = 1'b1;
            mem_address = {core_address[DATA_WIDTH-1:2], 2'b00};
            if (!mem_waitrequest) state_next = REFILL_WAIT;
         end
         REFILL_WAIT: begin
            if (mem_readdatavalid) begin
               set_fill         = 1'b1;
               set_fill_address = core_address;
               set_fill_data    = mem_readdata;
               state_next       = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Capture the victim line when a lookup misses
   always_ff @(posedge clk) begin
      if (rst) begin
         victim_addr <= '0;
         victim_data <= '0;
      end else if (miss) begin
         victim_addr <= {set_tag, index, OFFSET_W'(0)};
         victim_data <= set_dirty_data;
      end
   end

   // Event counters, wrapping modulo 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_hit  <= '0;
         cnt_miss <= '0;
         cnt_wb   <= '0;
      end else begin
         if (done)    cnt_hit  <= cnt_hit  + 32'd1;
         if (miss)    cnt_miss <= cnt_miss + 32'd1;
         if (wb_done) cnt_wb   <= cnt_wb   + 32'd1;
      end
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: drives cache_ctrl with a behavioural 32-line set and a memory with configurable stall and latency.
module tb_cache_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        core_read, core_write;
   logic [31:0] core_address, core_writedata, core_readdata;
   logic [3:0]  core_byteenable;
   logic        core_waitrequest;
   logic        set_read, set_write;
   logic [31:0] set_address, set_writedata, set_readdata, set_dirty_data;
   logic [3:0]  set_byteenable;
   logic        set_hit, set_valid, set_dirty;
   logic [24:0] set_tag;
   logic        set_fill;
   logic [31:0] set_fill_address, set_fill_data;
   logic        mem_read, mem_write;
   logic [31:0] mem_address, mem_writedata, mem_readdata;
   logic [3:0]  mem_byteenable;
   logic        mem_readdatavalid, mem_waitrequest;
   logic [31:0] cnt_hit, cnt_miss, cnt_wb;

   cache_ctrl #(.CACHE_LINE_SIZE(4), .CACHE_SET_DEPTH(32)) dut (
      .clk(clk), .rst(rst),
      .core_read(core_read), .core_write(core_write), .core_address(core_address),
      .core_writedata(core_writedata), .core_byteenable(core_byteenable),
      .core_readdata(core_readdata), .core_waitrequest(core_waitrequest),
      .set_read(set_read), .set_write(set_write), .set_address(set_address),
      .set_writedata(set_writedata), .set_byteenable(set_byteenable),
      .set_readdata(set_readdata), .set_hit(set_hit), .set_valid(set_valid),
      .set_dirty(set_dirty), .set_dirty_data(set_dirty_data), .set_tag(set_tag),
      .set_fill(set_fill), .set_fill_address(set_fill_address), .set_fill_data(set_fill_data),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
      .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
      .mem_waitrequest(mem_waitrequest),
      .cnt_hit(cnt_hit), .cnt_miss(cnt_miss), .cnt_wb(cnt_wb)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Behavioural direct-mapped set: 32 one-word lines, index = addr[6:2], tag = addr[31:7]
   logic [31:0] s_data  [32];
   logic [24:0] s_tag   [32];
   logic        s_valid [32];
   logic        s_dirty [32];
   logic [4:0]  s_idx;
   logic [4:0]  f_idx;
   assign s_idx          = set_address[6:2];
   assign f_idx          = set_fill_address[6:2];
   assign set_readdata   = s_data[s_idx];
   assign set_dirty_data = s_data[s_idx];
   assign set_tag        = s_tag[s_idx];
   assign set_valid      = s_valid[s_idx];
   assign set_dirty      = s_dirty[s_idx];
   assign set_hit        = s_valid[s_idx] && (s_tag[s_idx] == set_address[31:7]);

   always @(posedge clk) begin
      if (set_write && set_hit) begin
         for (int b = 0; b < 4; b++)
            if (set_byteenable[b]) s_data[s_idx][8*b +: 8] <= set_writedata[8*b +: 8];
         s_dirty[s_idx] <= 1'b1;
      end
      if (set_fill) begin
         s_data[f_idx]  <= set_fill_data;
         s_tag[f_idx]   <= set_fill_address[31:7];
         s_valid[f_idx] <= 1'b1;
         s_dirty[f_idx] <= 1'b0;
      end
   end

   // Memory: preloaded words, otherwise addr ^ 5A5A0000; stalls mem_stall cycles, answers resp_lat cycles after acceptance
   logic [31:0] mem_q [logic [31:0]];
   int          mem_stall = 0;
   int          resp_lat  = 1;
   int          stall_cnt = 0;
   int          pend      = 0;
   logic        rv        = 1'b0;
   logic [31:0] rdata_r   = '0;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (mem_q.exists(a)) return mem_q[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   assign mem_waitrequest   = (mem_read || mem_write) && (stall_cnt < mem_stall);
   assign mem_readdatavalid = rv;
   assign mem_readdata      = rdata_r;

   always @(posedge clk) begin
      if ((mem_read || mem_write) && mem_waitrequest) stall_cnt <= stall_cnt + 1;
      else                                            stall_cnt <= 0;
      if (mem_write && !mem_waitrequest) mem_q[mem_address] = mem_writedata;
      if (mem_read && !mem_waitrequest) rdata_r <= mem_val(mem_address);
      rv   <= (mem_read && !mem_waitrequest && resp_lat == 1) || (pend == 1);
      pend <= (mem_read && !mem_waitrequest) ? resp_lat - 1 : ((pend != 0) ? pend - 1 : 0);
   end

   // Memory-side scoreboard: expected transactions in order, plus stability and exclusivity tracking
   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
   } mtx_t;
   mtx_t        exp_mem[$];
   mtx_t        me;
   int          n_mrd = 0, n_mwr = 0, n_fill = 0, stab_err = 0, both_err = 0;
   bit          held = 1'b0;
   bit          h_wr;
   logic [31:0] h_addr, h_data;

   always @(negedge clk) begin
      if (mem_read && mem_write) both_err++;
      if (set_fill) begin
         n_fill++;
         check("fill_data", set_fill_data, mem_readdata);
      end
      if (rst) begin
         held = 1'b0;
      end else if (mem_read || mem_write) begin
         if (held && (h_addr !== mem_address || h_data !== mem_writedata || h_wr !== mem_write))
            stab_err++;
         if (mem_waitrequest) begin
            held = 1'b1; h_wr = mem_write; h_addr = mem_address; h_data = mem_writedata;
         end else begin
            held = 1'b0;
            if (mem_write) n_mwr++; else n_mrd++;
            if (exp_mem.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL mem_unexpected: got wr=%0d addr %h, expected no transaction", mem_write, mem_address);
            end else begin
               me = exp_mem.pop_front();
               check("mem_kind", 32'(mem_write), 32'(me.wr));
               check("mem_addr", mem_address, me.addr);
               if (me.wr) check("mem_wdata", mem_writedata, me.data);
               check("mem_be", 32'(mem_byteenable), 32'hF);
            end
         end
      end else begin
         held = 1'b0;
      end
   end

   // Core-side scoreboard: one expected entry per request, popped when the request completes
   typedef struct {
      bit          chk;
      logic [31:0] data;
      string       name;
   } cexp_t;
   cexp_t exp_core[$];
   cexp_t ce;

   always @(negedge clk) begin
      if (!rst && (core_read || core_write) && !core_waitrequest) begin
         if (exp_core.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL core_unexpected: got completion at %h, expected none", core_address);
         end else begin
            ce = exp_core.pop_front();
            if (ce.chk) check(ce.name, core_readdata, ce.data);
         end
      end
   end

   typedef struct {
      bit          rd, wr;
      logic [31:0] addr, wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
      int          lat, stall, rlat;
      bit          miss, dirty;
      logic [31:0] wb_addr, wb_data;
   } vec_t;

   function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic [31:0] rdata, input int lat, input int stall,
                               input int rlat, input bit miss, input bit dirty,
                               input logic [31:0] wb_addr, input logic [31:0] wb_data);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be; v.rdata = rdata;
      v.lat = lat; v.stall = stall; v.rlat = rlat; v.miss = miss; v.dirty = dirty;
      v.wb_addr = wb_addr; v.wb_data = wb_data;
      return v;
   endfunction

   logic [31:0] exp_hit = '0, exp_miss = '0, exp_wb = '0;

   // Issue one request, wait for completion, then check latency, counters and memory/fill traffic
   task automatic run_vec(input vec_t v, input int id);
      int cyc = 0;
      int rd0 = n_mrd;
      int wr0 = n_mwr;
      int f0  = n_fill;
      mem_stall = v.stall;
      resp_lat  = v.rlat;
      if (v.dirty) exp_mem.push_back('{1'b1, v.wb_addr, v.wb_data});
      if (v.miss)  exp_mem.push_back('{1'b0, {v.addr[31:2], 2'b00}, 32'h0});
      exp_core.push_back('{v.rd && !v.wr, v.rdata, $sformatf("v%0d_rdata", id)});
      core_read = v.rd; core_write = v.wr; core_address = v.addr;
      core_writedata = v.wdata; core_byteenable = v.be;
      do begin
         @(negedge clk);
         cyc++;
      end while (core_waitrequest && cyc < 100);
      if (core_waitrequest) begin
         n_cmp++; n_bad++;
         $display("FAIL v%0d_timeout: got no completion in %0d cycles, expected %0d", id, cyc, v.lat);
         exp_core.delete();
         exp_mem.delete();
      end
      check($sformatf("v%0d_latency", id), 32'(cyc), 32'(v.lat));
      @(posedge clk); #1;
      core_read = 1'b0; core_write = 1'b0;
      exp_hit  = exp_hit + 32'd1;
      exp_miss = exp_miss + 32'(v.miss);
      exp_wb   = exp_wb + 32'(v.dirty);
      check($sformatf("v%0d_cnt_hit", id), cnt_hit, exp_hit);
      check($sformatf("v%0d_cnt_miss", id), cnt_miss, exp_miss);
      check($sformatf("v%0d_cnt_wb", id), cnt_wb, exp_wb);
      check($sformatf("v%0d_mem_reads", id), 32'(n_mrd - rd0), 32'(v.miss));
      check($sformatf("v%0d_mem_writes", id), 32'(n_mwr - wr0), 32'(v.dirty));
      check($sformatf("v%0d_fills", id), 32'(n_fill - f0), 32'(v.miss));
      check($sformatf("v%0d_mem_pending", id), 32'(exp_mem.size()), 32'd0);
      exp_mem.delete();
   endtask

   vec_t vecs[16];
   int   f0, cyc;

   initial begin
      core_read = 1'b0; core_write = 1'b0; core_address = '0;
      core_writedata = '0; core_byteenable = '0;
      for (int i = 0; i < 32; i++) begin
         s_data[i] = '0; s_tag[i] = '0; s_valid[i] = 1'b0; s_dirty[i] = 1'b0;
      end
      mem_q[32'h100] = 32'hDEAD_BEEF;
      mem_q[32'h180] = 32'hCAFE_F00D;

      //         rd wr addr           wdata          be     rdata          lat stl R  miss dirty wb_addr  wb_data
      vecs[0]  = mk(1, 0, 32'h100,      32'h0,         4'h0, 32'hDEADBEEF, 8,  0, 3, 1, 0, 32'h0,   32'h0);
      vecs[1]  = mk(0, 1, 32'h100,      32'h11223344,  4'h3, 32'h0,        2,  0, 1, 0, 0, 32'h0,   32'h0);
      vecs[2]  = mk(1, 0, 32'h100,      32'h0,         4'h0, 32'hDEAD3344, 2,  0, 1, 0, 0, 32'h0,   32'h0);
      vecs[3]  = mk(1, 0, 32'h180,      32'h0,         4'h0, 32'hCAFEF00D, 8,  0, 2, 1, 1, 32'h100, 32'hDEAD3344);
      vecs[4]  = mk(1, 0, 32'h104,      32'h0,         4'h0, 32'h5A5A0104, 6,  0, 1, 1, 0, 32'h0,   32'h0);
      vecs[5]  = mk(1, 0, 32'h108,      32'h0,         4'h0, 32'h5A5A0108, 11, 2, 4, 1, 0, 32'h0,   32'h0);
      vecs[6]  = mk(1, 0, 32'h104,      32'h0,         4'h0, 32'h5A5A0104, 2,  0, 1, 0, 0, 32'h0,   32'h0);
      vecs[7]  = mk(1, 0, 32'h108,      32'h0,         4'h0, 32'h5A5A0108, 2,  0, 1, 0, 0, 32'h0,   32'h0);
      vecs[8]  = mk(0, 1, 32'h180,      32'hAABBCCDD,  4'hC, 32'h0,        2,  0, 1, 0, 0, 32'h0,   32'h0);
      vecs[9]  = mk(1, 0, 32'h100,      32'h0,         4'h0, 32'hDEAD3344, 18, 5, 2, 1, 1, 32'h180, 32'hAABBF00D);
      vecs[10] = mk(0, 1, 32'h200,      32'h12345678,  4'hF, 32'h0,        6,  0, 1, 1, 0, 32'h0,   32'h0);
      vecs[11] = mk(1, 0, 32'h200,      32'h0,         4'h0, 32'h12345678, 2,  0, 1, 0, 0, 32'h0,   32'h0);
      vecs[12] = mk(1, 0, 32'h17C,      32'h0,         4'h0, 32'h5A5A017C, 6,  0, 1, 1, 0, 32'h0,   32'h0);
      vecs[13] = mk(1, 1, 32'h104,      32'hFEEDFACE,  4'hF, 32'h0,        2,  0, 1, 0, 0, 32'h0,   32'h0);
      vecs[14] = mk(1, 0, 32'h104,      32'h0,         4'h0, 32'hFEEDFACE, 2,  0, 1, 0, 0, 32'h0,   32'h0);
      vecs[15] = mk(1, 0, 32'hFFFFFFFC, 32'h0,         4'h0, 32'hA5A5FFFC, 6,  0, 1, 1, 0, 32'h0,   32'h0);

      // Reset state with no request pending
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_waitrequest", 32'(core_waitrequest), 32'd0);
      check("rst_mem_req", {30'd0, mem_read, mem_write}, 32'd0);
      check("rst_set_req", {29'd0, set_read, set_write, set_fill}, 32'd0);
      check("rst_core_readdata", core_readdata, 32'd0);
      check("rst_mem_address", mem_address, 32'd0);
      check("rst_fill_data", set_fill_data, 32'd0);
      check("rst_counters", cnt_hit | cnt_miss | cnt_wb, 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

      // Reset while waiting for a refill response; the late response must be dropped
      mem_stall = 0; resp_lat = 6;
      exp_mem.push_back('{1'b0, 32'h110, 32'h0});
      core_read = 1'b1; core_address = 32'h110;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(mem_read && !mem_waitrequest) && cyc < 20);
      check("rr_refill_issued", 32'(mem_read && !mem_waitrequest), 32'd1);
      @(posedge clk); #1 rst = 1'b1;
      f0 = n_fill;
      @(posedge clk); #1 rst = 1'b0; core_read = 1'b0;
      @(negedge clk);
      check("rr_mem_req_cleared", {30'd0, mem_read, mem_write}, 32'd0);
      repeat (8) @(posedge clk);
      #1;
      check("rr_no_fill", 32'(n_fill - f0), 32'd0);
      check("rr_cnt_hit", cnt_hit, 32'd0);
      check("rr_cnt_miss", cnt_miss, 32'd0);
      check("rr_cnt_wb", cnt_wb, 32'd0);
      exp_core.delete();
      exp_hit = '0; exp_miss = '0; exp_wb = '0;
      run_vec(mk(1, 0, 32'h110, 32'h0, 4'h0, 32'h5A5A0110, 6, 0, 1, 1, 0, 32'h0, 32'h0), 16);

      check("mem_stable_while_stalled", 32'(stab_err), 32'd0);
      check("mem_read_write_exclusive", 32'(both_err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Direct-mapped cache controller sitting between the core's data-side memory port and one `cache_set` instance. It sequences lookup, hit completion, dirty-line writeback and line refill, and drives the set's fill port from memory responses. Hit, miss and writeback events are counted. The core side and the memory side are both Avalon-MM, single-beat.

## Interface
Parameters:
- `CACHE_LINE_SIZE`, 4: line size in bytes. Only 4 is supported.
- `CACHE_SET_DEPTH`, 32: number of lines. Must match the attached set.

Ports. Widths use `DATA_WIDTH` = 32 from `core.svh`. One clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `core_read` / `core_write`  in  1  core request; held stable while `core_waitrequest` = 1
- `core_address`  in  32  byte address
- `core_writedata`  in  32  write data
- `core_byteenable`  in  4  write byte lanes
- `core_readdata`  out  32  read data; valid when the read completes
- `core_waitrequest`  out  1  stall the core
- `set_read` / `set_write`  out  1  to set `read` / `write`
- `set_address`, `set_writedata`, `set_byteenable`  out  32/32/4  to set
- `set_readdata`, `set_hit`, `set_valid`, `set_dirty`, `set_dirty_data`  in  from set
- `set_tag`  in  32-2-log2(DEPTH)  tag of the indexed line
- `set_fill`, `set_fill_address`, `set_fill_data`  out  1/32/32  to set fill port
- `mem_read` / `mem_write`  out  1  memory request
- `mem_address`  out  32  word-aligned; bits [1:0] = 0
- `mem_writedata`  out  32  writeback data
- `mem_byteenable`  out  4  always 4'hF
- `mem_readdata`  in  32  response data
- `mem_readdatavalid`  in  1  response strobe
- `mem_waitrequest`  in  1  memory stall
- `cnt_hit`, `cnt_miss`, `cnt_wb`  out  32  event counters

## Operation
- FSM states are IDLE, LOOKUP, WRITEBACK, REFILL, REFILL_WAIT. Reset state is IDLE.
- Routing:
  - `set_address`, `set_writedata` and `set_byteenable` are driven from the core inputs at all times.
  - `set_read` = `core_read` and `set_write` = `core_write`, gated to 0 outside LOOKUP.
- `core_waitrequest` = (`core_read` | `core_write`) & ~done. `done` is 1 only in LOOKUP with `set_hit` = 1.
- IDLE: on a request, go to LOOKUP. If `core_read` and `core_write` are both 1 (illegal), the write wins.
- LOOKUP: the set outputs are valid this cycle.
  - Hit: complete the request. For a read, `core_readdata` = `set_readdata`. For a write, the set performs the write (the set drives the dirty bit). `cnt_hit` += 1. Go to IDLE.
  - Miss: `cnt_miss` += 1. Register the victim address {`set_tag`, index, 2'b00} and `set_dirty_data`.
    - If `set_valid` & `set_dirty`: go to WRITEBACK.
    - Otherwise: go to REFILL.
- WRITEBACK:
  - Drive `mem_write` = 1 with `mem_address` = victim address and `mem_writedata` = captured data.
  - Hold until `mem_waitrequest` = 0. On that cycle, `cnt_wb` += 1 and go to REFILL.
- REFILL:
  - Drive `mem_read` = 1 with `mem_address` = {`core_address`[31:2], 2'b00}.
  - Hold until `mem_waitrequest` = 0, then go to REFILL_WAIT.
- REFILL_WAIT:
  - On `mem_readdatavalid`, drive for one cycle: `set_fill` = 1, `set_fill_address` = `core_address`, `set_fill_data` = `mem_readdata`.
  - Then go to IDLE. The held request re-looks-up and hits.
- `mem_readdatavalid` in any state other than REFILL_WAIT is ignored.
- Counters: 32-bit, wrap modulo 2^32, reset to 0.

## Timing
- Reset values: all outputs are 0 except `core_waitrequest`, which follows its equation (0 with no request). FSM state is IDLE.
- Read hit: request seen in cycle N (IDLE), completes in cycle N+1 (LOOKUP). Latency is 2 cycles.
- Throughput: at most one request per 2 cycles.
- Clean miss with zero memory wait and response R cycles after acceptance: completes at N + 2 (lookup) + 1 (REFILL) + R (REFILL_WAIT, including the fill cycle) + 2 (re-lookup).
- Dirty miss: adds 1 cycle plus memory stall cycles for WRITEBACK.
- Memory requests stay asserted with constant address and data until accepted. `mem_read` and `mem_write` are never both 1.
- `mem_readdatavalid` is never sampled in the same cycle the request is accepted.
- Fill-then-read: the fill written at cycle F is visible to the lookup presented at F+1.
- Reset mid-operation (any state): state returns to IDLE and `mem_read` / `mem_write` are 0 from the next cycle. A late response is dropped. Counters clear.

## Test plan
- Cold read of 0x100, memory returns 0xDEADBEEF after 3 cycles -> exactly one `mem_read` at 0x100, one `set_fill` with 0xDEADBEEF, core gets 0xDEADBEEF; `cnt_miss` = 1, then `cnt_hit` = 1.
- Write 0x11223344 with byteenable 4'b0011 to cached 0x100, then read 0x100 -> write completes 2 cycles after request; read returns 0xDEAD3344 with no memory traffic.
- Read 0x180 (same index, different tag, line dirty) -> `mem_write` to 0x100 with 0xDEAD3344 precedes `mem_read` to 0x180; `cnt_wb` = 1.
- `mem_waitrequest` held high 5 cycles during WRITEBACK and REFILL -> address and data stable, no duplicate requests, correct final data.
- `rst` pulsed in REFILL_WAIT, then a response arrives -> no `set_fill`, all counters 0, next request handled normally.
- Back-to-back hits to 0x104 and 0x108 -> each completes in 2 cycles; `cnt_hit` increments by 2.
